// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and types for the SPI register scheduler: register map,
// transaction entry layout and scheduler FSM states.
package pwm_ctrl_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] ADDR_EN_LO   = 7'd0;
  localparam logic [ADDR_W-1:0] ADDR_EN_HI   = 7'd1;
  localparam logic [ADDR_W-1:0] ADDR_MODE_LO = 7'd2;
  localparam logic [ADDR_W-1:0] ADDR_MODE_HI = 7'd3;
  localparam logic [ADDR_W-1:0] ADDR_DUTY    = 7'd4;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_APPLY       = 2'd1,
    S_WAIT_PERIOD = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// A push while full is ignored even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_reg_scheduler.sv
// Queues SPI register writes and applies them in order; enable/mode bytes take
// effect at once, duty is held back until the PWM period wraps.
module spi_reg_scheduler
  import pwm_ctrl_pkg::*;
#(
  parameter int MAX_ADDR   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              period_end,
  output logic [15:0]       en_out,
  output logic [15:0]       pwm_mode,
  output logic [DATA_W-1:0] duty,
  output logic              duty_pending,
  output logic [7:0]        drop_cnt,
  output logic              busy,
  output state_t            fsm_state
);

  // Handshake: an entry transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready depends only on registered queue state, never on wr_valid.

  state_t             state, state_nxt;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [ENTRY_W-1:0] hold;
  logic [DATA_W-1:0]  duty_shadow;
  logic               fifo_full, fifo_empty;
  logic               pop;
  logic               do_drop, wr_en_lo, wr_en_hi, wr_mode_lo, wr_mode_hi;
  logic               stage_duty, commit;
  logic [ADDR_W-1:0]  hold_addr;
  logic [DATA_W-1:0]  hold_data;
  logic               addr_bad;

  assign hold_addr = hold[ENTRY_W-1:DATA_W];
  assign hold_data = hold[DATA_W-1:0];
  assign addr_bad  = (hold_addr > ADDR_W'(MAX_ADDR));
  assign wr_ready  = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign fsm_state = state;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_valid),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (!fifo_empty) state_nxt = S_APPLY;
      S_APPLY:       state_nxt = (!addr_bad && hold_addr == ADDR_DUTY) ? S_WAIT_PERIOD : S_IDLE;
      S_WAIT_PERIOD: if (period_end || en_out == 16'h0000) state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    do_drop    = 1'b0;
    wr_en_lo   = 1'b0;
    wr_en_hi   = 1'b0;
    wr_mode_lo = 1'b0;
    wr_mode_hi = 1'b0;
    stage_duty = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE:  pop = !fifo_empty;
      S_APPLY: begin
        if (addr_bad) do_drop = 1'b1;
        else begin
          wr_en_lo   = (hold_addr == ADDR_EN_LO);
          wr_en_hi   = (hold_addr == ADDR_EN_HI);
          wr_mode_lo = (hold_addr == ADDR_MODE_LO);
          wr_mode_hi = (hold_addr == ADDR_MODE_HI);
          stage_duty = (hold_addr == ADDR_DUTY);
        end
      end
      // With all outputs disabled the PWM counter stalls, so commit immediately.
      S_WAIT_PERIOD: commit = period_end || (en_out == 16'h0000);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold         <= '0;
      en_out       <= '0;
      pwm_mode     <= '0;
      duty         <= '0;
      duty_shadow  <= '0;
      duty_pending <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (pop)        hold           <= fifo_dout;
      if (wr_en_lo)   en_out[7:0]    <= hold_data;
      if (wr_en_hi)   en_out[15:8]   <= hold_data;
      if (wr_mode_lo) pwm_mode[7:0]  <= hold_data;
      if (wr_mode_hi) pwm_mode[15:8] <= hold_data;
      if (do_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (stage_duty) begin
        duty_shadow  <= hold_data;
        duty_pending <= 1'b1;
      end
      if (commit) begin
        duty         <= duty_shadow;
        duty_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_scheduler.sv
// Directed bench for spi_reg_scheduler: each step drives inputs 1ns after the
// rising edge and checks outputs at that same point, away from the edge.
module tb_spi_reg_scheduler;
  import pwm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        period_end;
  logic [15:0] en_out;
  logic [15:0] pwm_mode;
  logic [7:0]  duty;
  logic        duty_pending;
  logic [7:0]  drop_cnt;
  logic        busy;
  state_t      fsm_state;

  int total = 0;
  int bad   = 0;

  spi_reg_scheduler #(.MAX_ADDR(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .period_end   (period_end),
    .en_out       (en_out),
    .pwm_mode     (pwm_mode),
    .duty         (duty),
    .duty_pending (duty_pending),
    .drop_cnt     (drop_cnt),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer; waits (bounded) for wr_ready, valid drops after the accepting edge.
  task automatic write(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 100 && !wr_ready; i++) step();
    if (!wr_ready) begin
      total++;
      bad++;
      $error("FAIL write_ready_timeout observed=%0b expected=1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) step();
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    period_end = 1'b0;
    step(3);
    check("rst_en_out", 32'(en_out), 32'h0);
    check("rst_pwm_mode", 32'(pwm_mode), 32'h0);
    check("rst_duty", 32'(duty), 32'h0);
    check("rst_pending", 32'(duty_pending), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);
    check("rst_state", 32'(fsm_state), 32'(S_IDLE));
    rst_n = 1'b1;
    step(2);

    // Basic enable write: E0 accept, E1 pop, E2 visible
    write(7'd0, 8'hA5);
    check("en_lo_after_e0", 32'(en_out), 32'h0);
    step();
    check("en_lo_after_e1", 32'(en_out), 32'h0);
    check("state_apply", 32'(fsm_state), 32'(S_APPLY));
    step();
    check("en_lo_after_e2", 32'(en_out), 32'h00A5);
    check("busy_cleared", 32'(busy), 32'h0);

    // Duty waits for period_end while outputs are enabled
    write(7'd0, 8'h01);
    step(2);
    check("en_lo_01", 32'(en_out), 32'h0001);
    write(7'd4, 8'h80);
    step(2);
    check("duty_pending_set", 32'(duty_pending), 32'h1);
    check("duty_held", 32'(duty), 32'h0);
    check("state_wait", 32'(fsm_state), 32'(S_WAIT_PERIOD));
    step(5);
    check("duty_still_held", 32'(duty), 32'h0);
    period_end = 1'b1;
    step();
    period_end = 1'b0;
    check("duty_commit_80", 32'(duty), 32'h80);
    check("pending_clear_80", 32'(duty_pending), 32'h0);
    step();
    check("busy_after_commit", 32'(busy), 32'h0);

    // Outputs disabled: commit on first WAIT_PERIOD edge
    write(7'd0, 8'h00);
    step(2);
    check("en_zero", 32'(en_out), 32'h0);
    write(7'd4, 8'h40);
    step(2);
    check("pending_idle_pwm", 32'(duty_pending), 32'h1);
    step();
    check("duty_commit_40", 32'(duty), 32'h40);
    check("pending_clear_40", 32'(duty_pending), 32'h0);

    // Ordering behind a staged duty, queue fills to 4
    write(7'd0, 8'h01);
    step(2);
    write(7'd4, 8'h55);
    write(7'd1, 8'hFF);
    write(7'd2, 8'h22);
    write(7'd3, 8'h33);
    write(7'd0, 8'h03);
    check("queue_full_ready", 32'(wr_ready), 32'h0);
    check("en_unchanged", 32'(en_out), 32'h0001);
    check("duty_unchanged_55", 32'(duty), 32'h40);
    check("pending_55", 32'(duty_pending), 32'h1);
    wr_valid = 1'b1;
    wr_addr  = 7'd0;
    wr_data  = 8'h77;
    step(2);
    wr_valid = 1'b0;
    period_end = 1'b1;
    step();
    period_end = 1'b0;
    check("duty_commit_55", 32'(duty), 32'h55);
    check("en_before_hi", 32'(en_out), 32'h0001);
    step(2);
    check("en_hi_ff", 32'(en_out), 32'hFF01);
    wait_idle();
    check("mode_final", 32'(pwm_mode), 32'h3322);
    check("en_final", 32'(en_out), 32'hFF03);
    check("ready_after_drain", 32'(wr_ready), 32'h1);

    // Out-of-range writes: counted, saturate at 255
    for (int i = 0; i < 10; i++) write(7'h05, 8'(i));
    wait_idle();
    check("drop_cnt_10", 32'(drop_cnt), 32'd10);
    for (int i = 0; i < 250; i++) write(7'h05, 8'(i));
    wait_idle();
    check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
    check("drop_en_kept", 32'(en_out), 32'hFF03);
    check("drop_mode_kept", 32'(pwm_mode), 32'h3322);
    check("drop_duty_kept", 32'(duty), 32'h55);

    // Reset with a staged duty and three queued entries
    write(7'd4, 8'hAA);
    write(7'd0, 8'h01);
    write(7'd1, 8'h02);
    write(7'd2, 8'h03);
    check("pre_rst_pending", 32'(duty_pending), 32'h1);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(en_out), 32'h0);
    check("mid_rst_mode", 32'(pwm_mode), 32'h0);
    check("mid_rst_duty", 32'(duty), 32'h0);
    check("mid_rst_pending", 32'(duty_pending), 32'h0);
    check("mid_rst_drop", 32'(drop_cnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(wr_ready), 32'h1);
    step(2);
    rst_n = 1'b1;
    step(2);
    period_end = 1'b1;
    step();
    period_end = 1'b0;
    step(4);
    check("post_rst_duty", 32'(duty), 32'h0);
    check("post_rst_en", 32'(en_out), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
